// File: rtl/expr_lane_pipe_pkg.sv
// expr_lane_pipe_pkg: operator encoding and saturation helper shared by the lane ALU and top.
// Optional feature macro: EXPR_LANE_PIPE_SAT_EN (saturating ADD/SUB in expr_lane).

package expr_lane_pipe_pkg;

    // 4-bit operator codes; 12..15 are reserved and evaluate to zero.
    typedef enum logic [3:0] {
        OpAdd    = 4'd0,
        OpSub    = 4'd1,
        OpAnd    = 4'd2,
        OpXnor   = 4'd3,
        OpShl    = 4'd4,
        OpShr    = 4'd5,
        OpLt     = 4'd6,
        OpCeq    = 4'd7,
        OpMul    = 4'd8,
        OpMod    = 4'd9,
        OpRedand = 4'd10,
        OpRedxor = 4'd11
    } op_t;

    localparam int unsigned OP_COUNT = 12;

    // Width of the exact intermediate fed to sat_clamp; lanes must be narrower than this.
    localparam int unsigned SAT_VAL_W = 64;

    // Clamp an exact (non-overflowed) result into the w-bit signed or unsigned range.
    function automatic logic signed [SAT_VAL_W-1:0] sat_clamp(
        input logic signed [SAT_VAL_W-1:0] val,
        input int unsigned                 w,
        input logic                        is_signed
    );
        logic signed [SAT_VAL_W-1:0] hi;
        logic signed [SAT_VAL_W-1:0] lo;
        if (is_signed) begin
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (w - 1));
        end else begin
            hi = (64'sd1 <<< w) - 64'sd1;
            lo = 64'sd0;
        end
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/expr_lane_pipe_lane.sv
// expr_lane: purely combinational single-lane ALU evaluating one mixed signed/unsigned operator.
// Optional feature macro: EXPR_LANE_PIPE_SAT_EN (ADD/SUB clamp instead of wrapping).

module expr_lane
    import expr_lane_pipe_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic [3:0]   op_i,
    input  logic         signed_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    // W always fits in W bits because 2^W > W, so shift amounts compare without widening.
    localparam logic [W-1:0] W_CODE = W[W-1:0];

`ifdef EXPR_LANE_PIPE_SAT_EN
    logic signed [SAT_VAL_W-1:0] a_x;
    logic signed [SAT_VAL_W-1:0] b_x;
    logic signed [SAT_VAL_W-1:0] wide;
    logic signed [SAT_VAL_W-1:0] clamped;
`endif

    // Operator decode; each branch is kept signed-only or unsigned-only so that mixed
    // signedness never silently turns a signed operation into an unsigned one.
    always_comb begin
        y_o = '0;
`ifdef EXPR_LANE_PIPE_SAT_EN
        a_x     = signed_i ? 64'($signed(a_i)) : 64'(a_i);
        b_x     = signed_i ? 64'($signed(b_i)) : 64'(b_i);
        wide    = '0;
        clamped = '0;
`endif
        case (op_i)
            OpAdd: begin
`ifdef EXPR_LANE_PIPE_SAT_EN
                wide    = a_x + b_x;
                clamped = sat_clamp(wide, W, signed_i);
                y_o     = clamped[W-1:0];
`else
                y_o = a_i + b_i;
`endif
            end
            OpSub: begin
`ifdef EXPR_LANE_PIPE_SAT_EN
                wide    = a_x - b_x;
                clamped = sat_clamp(wide, W, signed_i);
                y_o     = clamped[W-1:0];
`else
                y_o = a_i - b_i;
`endif
            end
            OpAnd:  y_o = a_i & b_i;
            OpXnor: y_o = ~(a_i ^ b_i);
            // Shift amount is always unsigned.
            OpShl:  y_o = (b_i >= W_CODE) ? '0 : (a_i << b_i);
            OpShr: begin
                if (signed_i) begin
                    if (b_i >= W_CODE) begin
                        y_o = {W{a_i[W-1]}};
                    end else begin
                        y_o = $signed(a_i) >>> b_i;
                    end
                end else begin
                    y_o = (b_i >= W_CODE) ? '0 : (a_i >> b_i);
                end
            end
            OpLt: begin
                if (signed_i) begin
                    y_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
                end else begin
                    y_o = {{(W-1){1'b0}}, (a_i < b_i)};
                end
            end
            OpCeq:  y_o = {{(W-1){1'b0}}, (a_i === b_i)};
            // Low W bits of the product do not depend on signedness.
            OpMul:  y_o = a_i * b_i;
            OpMod: begin
                if (b_i == '0) begin
                    y_o = '0;
                end else if (signed_i) begin
                    y_o = $signed(a_i) % $signed(b_i);
                end else begin
                    y_o = a_i % b_i;
                end
            end
            OpRedand: y_o = {{(W-1){1'b0}}, &a_i};
            OpRedxor: y_o = {{(W-1){1'b0}}, ^a_i};
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe: LANES-wide expression ALU feeding a STAGES-deep valid/ready register pipeline.
// Optional feature macro: EXPR_LANE_PIPE_SAT_EN (saturating ADD/SUB, handled in expr_lane).

module expr_lane_pipe
    import expr_lane_pipe_pkg::*;
#(
    parameter int unsigned W      = 6,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic               in_signed,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_y,
    output logic [LANES-1:0]   out_zero
);

    logic [LANES*W-1:0] lane_y;
    logic [LANES-1:0]   lane_zero;

    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  valid_d;
    logic [LANES*W-1:0] y_q    [STAGES];
    logic [LANES*W-1:0] y_d    [STAGES];
    logic [LANES-1:0]   zero_q [STAGES];
    logic [LANES-1:0]   zero_d [STAGES];
    logic [STAGES-1:0]  adv;

    // Lane ALUs evaluate straight off the input bus; only stage 0 captures their results.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        expr_lane #(
            .W(W)
        ) u_lane (
            .op_i     (in_op),
            .signed_i (in_signed),
            .a_i      (in_a[i*W +: W]),
            .b_i      (in_b[i*W +: W]),
            .y_o      (lane_y[i*W +: W])
        );
        assign lane_zero[i] = (lane_y[i*W +: W] == '0);
    end

    // Advance enables ripple back from the output so a draining stage frees the one behind it.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            nxt    = ~valid_q[k] | nxt;
            adv[k] = nxt;
        end
    end

    // Next-state: advancing stages take the previous stage's beat; data only moves with a valid
    // beat so a stalled or empty output never changes its payload.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        zero_d  = zero_q;
        if (adv[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                y_d[0]    = lane_y;
                zero_d[0] = lane_zero;
            end
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    y_d[k]    = y_q[k-1];
                    zero_d[k] = zero_q[k-1];
                end
            end
        end
    end

    // Stage registers; synchronous reset drops every in-flight beat and zeroes the payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                y_q[k]    <= '0;
                zero_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_y     = y_q[STAGES-1];
    assign out_zero  = zero_q[STAGES-1];

endmodule

// File: tb/tb_expr_lane_pipe.sv
// tb_expr_lane_pipe: scoreboard bench for expr_lane_pipe with an integer reference model.
// Honours EXPR_LANE_PIPE_SAT_EN when the design is built with saturating ADD/SUB.

module tb_expr_lane_pipe;

    localparam int unsigned W      = 6;
    localparam int unsigned LANES  = 4;
    localparam int unsigned STAGES = 2;
    localparam int unsigned N      = LANES * W;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [3:0]     in_op     = 4'd0;
    logic           in_signed = 1'b0;
    logic [N-1:0]   in_a      = '0;
    logic [N-1:0]   in_b      = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [N-1:0]   out_y;
    logic [LANES-1:0] out_zero;

    typedef struct packed {
        logic [N-1:0]     y;
        logic [LANES-1:0] z;
    } beat_t;

    beat_t sb[$];
    beat_t mon_exp;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    out_cnt = 0;
    int    ready_mode = 1;  // 0: hold off, 1: always ready, 2: random

    expr_lane_pipe #(
        .W      (W),
        .LANES  (LANES),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Downstream readiness, changed shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int sval(input logic [W-1:0] v, input logic sgn);
        if (sgn && v[W-1]) return int'(v) - (1 << W);
        return int'(v);
    endfunction

    function automatic logic [W-1:0] ref_lane(input int op, input logic sgn,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        int av, bv, ub, r, lo, hi, p;
        av = sval(a, sgn);
        bv = sval(b, sgn);
        ub = int'(b);
        lo = sgn ? -(1 << (W - 1)) : 0;
        hi = sgn ? (1 << (W - 1)) - 1 : (1 << W) - 1;
        r  = 0;
        case (op)
            0:  r = av + bv;
            1:  r = av - bv;
            2:  r = av & bv;
            3:  r = ~(av ^ bv);
            4:  r = (ub >= int'(W)) ? 0 : av * (1 << ub);
            5: begin
                if (ub >= int'(W)) begin
                    r = (sgn && av < 0) ? -1 : 0;
                end else begin
                    p = 1 << ub;
                    // floor division for negative values
                    r = (av < 0) ? -((-av + p - 1) / p) : av / p;
                end
            end
            6:  r = (av < bv) ? 1 : 0;
            7:  r = (a == b) ? 1 : 0;
            8:  r = av * bv;
            9:  r = (bv == 0) ? 0 : av % bv;
            10: r = (int'(a) == (1 << W) - 1) ? 1 : 0;
            11: r = $countones(a) % 2;
            default: r = 0;
        endcase
`ifdef EXPR_LANE_PIPE_SAT_EN
        if (op == 0 || op == 1) begin
            if (r > hi) r = hi;
            if (r < lo) r = lo;
        end
`else
        if (lo > hi) r = 0;  // unreachable; keeps lo/hi used in the wrapping build
`endif
        return r[W-1:0];
    endfunction

    function automatic beat_t model_beat(input logic [3:0] op, input logic sgn,
                                         input logic [N-1:0] a, input logic [N-1:0] b);
        beat_t bt;
        for (int i = 0; i < int'(LANES); i++) begin
            bt.y[i*W +: W] = ref_lane(int'(op), sgn, a[i*W +: W], b[i*W +: W]);
            bt.z[i]        = (bt.y[i*W +: W] == '0);
        end
        return bt;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output transfer pops the oldest expected beat.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got out_y=%0h with no beat expected", out_y);
            end else begin
                mon_exp = sb.pop_front();
                check("out_y", 64'(out_y), 64'(mon_exp.y));
                check("out_zero", 64'(out_zero), 64'(mon_exp.z));
            end
            out_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [3:0] op, input logic sgn,
                        input logic [N-1:0] a, input logic [N-1:0] b);
        in_op     = op;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready && !reset) begin
                sb.push_back(model_beat(op, sgn, a, b));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never asserted for op %0d", op);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int accepted;
        int idx;
        int base;
        logic [N-1:0] held;
        logic         held_ok;
        logic [N-1:0] bp_a [5];

        // Reset held with in_valid high: nothing may leak out.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_a     = 24'h123456;
        in_b     = 24'h654321;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_y", 64'(out_y), 64'd0);
            check("rst_out_zero", 64'(out_zero), 64'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // ADD signed: lane0 -3+5, lane1 0x1F+1 (wraps or saturates); also measures latency.
        send(4'd0, 1'b1, {6'h11, 6'h2A, 6'h1F, 6'h3D}, {6'h07, 6'h3C, 6'h01, 6'h05});
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("latency", 64'(lat), 64'(STAGES));
        drain();

        // Directed operator corners.
        send(4'd5, 1'b1, {6'h3F, 6'h01, 6'h2C, 6'h20}, {6'h01, 6'h02, 6'h06, 6'h07});
        send(4'd5, 1'b0, {6'h3F, 6'h01, 6'h2C, 6'h20}, {6'h01, 6'h02, 6'h06, 6'h07});
        send(4'd6, 1'b1, {6'h20, 6'h1F, 6'h00, 6'h3F}, {6'h1F, 6'h20, 6'h00, 6'h01});
        send(4'd6, 1'b0, {6'h20, 6'h1F, 6'h00, 6'h3F}, {6'h1F, 6'h20, 6'h00, 6'h01});
        send(4'd9, 1'b1, {6'h20, 6'h05, 6'h3B, 6'h3B}, {6'h3F, 6'h3D, 6'h3D, 6'h03});
        send(4'd9, 1'b1, {6'h20, 6'h3F, 6'h15, 6'h3B}, {6'h00, 6'h00, 6'h00, 6'h00});
        send(4'd9, 1'b0, {6'h20, 6'h3F, 6'h15, 6'h3B}, {6'h00, 6'h00, 6'h00, 6'h00});
        send(4'd1, 1'b0, {6'h00, 6'h3F, 6'h10, 6'h05}, {6'h01, 6'h3F, 6'h20, 6'h02});
        send(4'd4, 1'b0, {6'h3F, 6'h01, 6'h21, 6'h15}, {6'h3F, 6'h05, 6'h06, 6'h01});
        send(4'd13, 1'b1, {6'h3F, 6'h01, 6'h21, 6'h15}, {6'h3F, 6'h05, 6'h06, 6'h01});
        drain();

        // Random operators, signedness and data with random downstream stalls.
        ready_mode = 2;
        for (int i = 0; i < 250; i++) begin
            send(4'($urandom_range(0, 15)), 1'($urandom), N'($urandom), N'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Backpressure: 6 cycles of stall with 5 beats queued.
        ready_mode = 0;
        idle(2);
        for (int i = 0; i < 5; i++) bp_a[i] = N'(24'h041041 * (i + 1));
        idx      = 0;
        accepted = 0;
        held_ok  = 1'b0;
        held     = '0;
        for (int c = 0; c < 6; c++) begin
            in_op     = 4'd0;
            in_signed = 1'b0;
            in_a      = bp_a[idx];
            in_b      = 24'h010203;
            in_valid  = 1'b1;
            @(negedge clk);
            if (held_ok) check("bp_y_stable", 64'(out_y), 64'(held));
            if (out_valid && !held_ok) begin
                held    = out_y;
                held_ok = 1'b1;
            end
            if (in_ready) begin
                sb.push_back(model_beat(in_op, in_signed, in_a, in_b));
                idx++;
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(accepted), 64'd2);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        ready_mode = 1;
        base       = out_cnt;
        for (int c = 0; c < 5; c++) begin
            if (idx < 5) begin
                in_a     = bp_a[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_no_gap", 64'(out_valid), 64'd1);
            if (in_valid && in_ready) begin
                sb.push_back(model_beat(in_op, in_signed, in_a, in_b));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_all_sent", 64'(idx), 64'd5);
        check("bp_out_count", 64'(out_cnt - base), 64'd5);
        drain();

        // Reset with two beats in flight: they must vanish.
        ready_mode = 0;
        idle(1);
        send(4'd2, 1'b0, 24'hFFFFFF, 24'hABCDEF);
        send(4'd3, 1'b0, 24'h000000, 24'h000000);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_flush_valid", 64'(out_valid), 64'd0);
        reset      = 1'b0;
        ready_mode = 1;
        base       = out_cnt;
        send(4'd8, 1'b1, {6'h3F, 6'h05, 6'h1F, 6'h02}, {6'h3F, 6'h3D, 6'h02, 6'h03});
        drain();
        idle(5);
        check("rst_one_beat", 64'(out_cnt - base), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_lane_pipe.md
Name: expr_lane_pipe

Overview:
- Parametrised, pipelined successor to the single-shot combinational expression blocks.
- Evaluates one selectable mixed signed/unsigned operator across LANES independent W-bit lanes.
- Results are registered through a STAGES-deep valid/ready pipeline.
- Used as a regression target for width/sign-extension semantics under backpressure.

Parameters:
- W, 6, lane operand/result width (>=2)
- LANES, 4, number of parallel lanes
- STAGES, 2, pipeline register stages (>=1), equals latency

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept a beat this cycle
- in_op  in  4  operator select (encoding below)
- in_signed  in  1  1: operands treated as signed two's-complement; 0: unsigned
- in_a  in  LANES*W  lane i operand a at bits [i*W +: W]
- in_b  in  LANES*W  lane i operand b, same packing
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_y  out  LANES*W  lane results, same packing as in_a
- out_zero  out  LANES  lane i result == 0

Behaviour:
- Reset: all stage valids cleared; out_valid=0, out_y=0, out_zero=0; in_ready=1 in the first cycle after reset. Reset mid-operation discards every in-flight beat.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Once out_valid=1, out_y and out_zero stay stable until the beat transfers.
- Pipeline:
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances on out_ready.
  - in_ready = stage 0 empty or stage 0 advancing (combinational from out_ready through the chain).
  - Full throughput is 1 beat/cycle. Latency is exactly STAGES cycles from the accept edge to out_valid when never stalled.
  - Order is preserved and no beat is dropped or duplicated.
  - Accept and emit in the same cycle when full is legal.
- Datapath: the lane computation is combinational at the input and is captured into stage 0. Later stages only carry registered results.
- Operators (a, b sign-extended per in_signed when widening; result truncated to W):
  - 0 ADD: a+b, wraps.
  - 1 SUB: a-b, wraps.
  - 2 AND.
  - 3 XNOR.
  - 4 SHL: a<<b, with b always unsigned; b>=W gives 0.
  - 5 SHR:
    - Signed: arithmetic; b>=W gives all sign bits.
    - Unsigned: logical; b>=W gives 0.
  - 6 LT: 1-bit a<b per signedness, zero-extended.
  - 7 CEQ: a===b, zero-extended.
  - 8 MUL: low W bits of the product.
  - 9 MOD:
    - a%b; when signed, the result takes the sign of a.
    - b==0 gives result 0, a decided value, never X.
  - 10 REDAND: &a zero-extended.
  - 11 REDXOR: ^a zero-extended.
  - 12-15 reserved: result 0.
- in_op and in_signed are captured with the operands; changing them while stalled has no effect on accepted beats.

Optional Feature:
- EXPR_LANE_PIPE_SAT_EN defined:
  - ADD/SUB saturate instead of wrapping.
  - Signed results clamp to [-2^(W-1), 2^(W-1)-1].
  - Unsigned results clamp to [0, 2^W-1].
- Undefined: ADD/SUB wrap modulo 2^W. All other operators are identical either way.

Decomposition:
- Package expr_lane_pipe_pkg:
  - op_t enum (4-bit codes above).
  - OP_COUNT constant.
  - Pure function for the saturation clamp.
- Sub-module expr_lane:
  - Purely combinational single-lane ALU (W, op, signed, a, b -> y).
  - Instantiated LANES times via generate.
  - Pipeline registers and handshake live in the top.

Test Plan (W=6, LANES=4, STAGES=2):
- Reset held 3 cycles with in_valid=1 -> out_valid=0, out_y=0, out_zero=0 throughout. After release, in_ready=1 and the first beat appears exactly 2 cycles after its accept.
- ADD signed, lane0 a=6'h3D(-3) b=6'h05 -> y=6'h02. Lane1 a=6'h1F b=6'h01 -> 6'h20 without SAT_EN, 6'h1F with SAT_EN.
- SHR lane0 a=6'h20 b=6'h07:
  - signed -> 6'h3F
  - unsigned -> 6'h00, out_zero[0]=1
- LT a=6'h3F b=6'h01 -> 1 signed, 0 unsigned. MOD a=6'h3B(-5) b=6'h03 signed -> 6'h3E(-2). MOD any a, b=0 -> 0.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles with in_valid=1 and 5 distinct beats queued.
  - Expected: exactly 2 accepted, in_ready=0 after that, out_y stable.
  - Then out_ready=1: all 5 beats emerge in order at 1/cycle with no gaps.
- Reset asserted while 2 beats are in flight -> out_valid=0 the next cycle and the beats are never emitted. The first post-reset beat emerges with correct data.
